// File: rtl/mfp_ahb_uart_tx_pkg.sv
// Shared constants for the AHB-Lite UART transmitter: register offsets,
// STATUS bit positions, slave base address and the data-phase record.
package mfp_ahb_uart_tx_pkg;

    localparam logic [31:0] MFP_UART_TX_ADDR = 32'h1F80_1000;

    // Word offsets decoded from HADDR[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_PARITY    = 4;
    localparam int ST_COUNT_LSB = 8;

    typedef struct packed {
        logic       valid;
        logic       write;
        logic [1:0] reg_sel;
    } ahb_dphase_t;

    function automatic logic [31:0] status_word(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       overflow,
        input logic       parity_en,
        input logic [7:0] count
    );
        logic [31:0] w;
        w                     = '0;
        w[ST_FULL]            = full;
        w[ST_EMPTY]           = empty;
        w[ST_BUSY]            = busy;
        w[ST_OVERFLOW]        = overflow;
        w[ST_PARITY]          = parity_en;
        w[ST_COUNT_LSB +: 8]  = count;
        return w;
    endfunction

endpackage

// File: rtl/mfp_ahb_uart_tx_fifo.sv
// Synchronous TX FIFO with occupancy count; a pop on empty is ignored, while
// push+pop on a full FIFO is accepted because the pop frees the slot.
module mfp_uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     push_ok,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             pop_ok;

    assign full     = (count_reg == FULL_COUNT);
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    // Head word is presented ahead of the pop so the shifter loads on the pop edge
    assign pop_data = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite UART transmitter: bus writes feed a FIFO drained as 8N1 frames,
// or 8E1 frames when MFP_UART_TX_PARITY_EN is defined.
module mfp_ahb_uart_tx
    import mfp_ahb_uart_tx_pkg::*;
#(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        HCLK,
    input  logic        SI_Reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        UART_TX,
    output logic        TX_IRQ
);
    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
`ifdef MFP_UART_TX_PARITY_EN
    localparam logic        PARITY_EN   = 1'b1;
`else
    localparam logic        PARITY_EN   = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY_BIT,
        ST_STOP
    } tx_state_t;

    tx_state_t   state_reg;
    logic [15:0] baud_reg;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  shift_reg;
`ifdef MFP_UART_TX_PARITY_EN
    logic        parity_reg;
`endif
    logic        tx_reg;
    logic        irq_reg;
    logic        overflow_reg;
    logic [31:0] hrdata_reg;
    ahb_dphase_t dphase_reg;

    logic          addr_valid;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic [7:0]    pop_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] fifo_count_next;
    logic          baud_done;
    logic          overflow_clear;
    logic          overflow_next;
    logic          busy_next;
    logic [7:0]    count_byte;
    logic [31:0]   read_value;
    logic          unused_bits;

    assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:8]};

    assign addr_valid     = HSEL && HREADY && HTRANS[1];
    assign push           = dphase_reg.valid && dphase_reg.write && (dphase_reg.reg_sel == REG_TXDATA);
    assign overflow_clear = dphase_reg.valid && dphase_reg.write && (dphase_reg.reg_sel == REG_STATUS);
    assign baud_done      = (baud_reg == 16'd0);
    assign pop            = !fifo_empty && ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && baud_done));

    mfp_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (HCLK),
        .srst       (SI_Reset),
        .push       (push),
        .push_data  (HWDATA[7:0]),
        .pop        (pop),
        .pop_data   (pop_data),
        .push_ok    (push_ok),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

    // STATUS reads see the state after this edge, so a write immediately
    // followed by a read already reports the new byte.
    always_comb begin
        overflow_next = overflow_reg;
        if (overflow_clear) begin
            overflow_next = 1'b0;
        end else if (push && !push_ok) begin
            overflow_next = 1'b1;
        end
        busy_next = (state_reg != ST_IDLE);
        if (pop) begin
            busy_next = 1'b1;
        end else if ((state_reg == ST_STOP) && baud_done) begin
            busy_next = 1'b0;
        end
    end

    assign count_byte = 8'(fifo_count_next);

    always_comb begin
        read_value = '0;
        if (HADDR[3:2] == REG_STATUS) begin
            read_value = status_word(fifo_count_next == CW'(FIFO_DEPTH),
                                     fifo_count_next == '0,
                                     busy_next,
                                     overflow_next,
                                     PARITY_EN,
                                     count_byte);
        end
    end

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            dphase_reg   <= '0;
            hrdata_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= overflow_next;
            if (addr_valid) begin
                dphase_reg <= '{valid: 1'b1, write: HWRITE, reg_sel: HADDR[3:2]};
            end else begin
                dphase_reg.valid <= 1'b0;
            end
            hrdata_reg <= (addr_valid && !HWRITE) ? read_value : 32'd0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            state_reg   <= ST_IDLE;
            baud_reg    <= 16'd0;
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 8'd0;
`ifdef MFP_UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
            tx_reg      <= 1'b1;
            irq_reg     <= 1'b1;
        end else begin
            irq_reg <= (state_reg == ST_IDLE) && fifo_empty;
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        shift_reg  <= pop_data;
`ifdef MFP_UART_TX_PARITY_EN
                        parity_reg <= ^pop_data;
`endif
                        tx_reg     <= 1'b0;
                        baud_reg   <= BAUD_RELOAD;
                        state_reg  <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        tx_reg      <= shift_reg[0];
                        bit_cnt_reg <= 3'd0;
                        baud_reg    <= BAUD_RELOAD;
                        state_reg   <= ST_DATA;
                    end else begin
                        baud_reg <= baud_reg - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_reg <= BAUD_RELOAD;
                        if (bit_cnt_reg == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
                            tx_reg    <= parity_reg;
                            state_reg <= ST_PARITY_BIT;
`else
                            tx_reg    <= 1'b1;
                            state_reg <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        baud_reg <= baud_reg - 16'd1;
                    end
                end
`ifdef MFP_UART_TX_PARITY_EN
                ST_PARITY_BIT: begin
                    if (baud_done) begin
                        tx_reg    <= 1'b1;
                        baud_reg  <= BAUD_RELOAD;
                        state_reg <= ST_STOP;
                    end else begin
                        baud_reg <= baud_reg - 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_done) begin
                        // Chain straight into the next start bit when data is waiting
                        if (pop) begin
                            shift_reg  <= pop_data;
`ifdef MFP_UART_TX_PARITY_EN
                            parity_reg <= ^pop_data;
`endif
                            tx_reg     <= 1'b0;
                            baud_reg   <= BAUD_RELOAD;
                            state_reg  <= ST_START;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        baud_reg <= baud_reg - 16'd1;
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign HRDATA    = hrdata_reg;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign UART_TX   = tx_reg;
    assign TX_IRQ    = irq_reg;

endmodule
